// File: rtl/fir_out_serializer.sv
// fir_out_serializer: rounds and saturates FIR results to 16 bits, buffers
// them in a small FIFO and streams each word as low byte then high byte.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid, in_data    one-cycle strobe with a signed ACC_W-bit result
//   out_byte, out_valid  byte stream toward the pins
//   out_ready, out_last  consumer accept; high byte of the word
//   level                FIFO occupancy (0..FIFO_DEPTH)
//   ovf, sat, clr_flags  sticky drop / clamp flags and their clear
module fir_out_serializer #(
    parameter int ACC_W      = 20,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [ACC_W-1:0]              in_data,
    output logic [7:0]                    out_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          ovf,
    output logic                          sat,
    input  logic                          clr_flags
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int TW  = ACC_W + 1;
    // Arithmetic width: wide enough for the rounded sum and the 16-bit limits.
    localparam int EW  = (TW > 17) ? TW : 17;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EW-1:0] RND  = (SHIFT > 0) ? (EW'(1) << RSH) : '0;
    localparam logic signed [EW-1:0] MAXV = EW'(32767);
    localparam logic signed [EW-1:0] MINV = ~MAXV;
    localparam logic [AW:0]          FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } state_t;

    state_t state;

    logic signed [EW-1:0] t_ext;
    logic signed [EW-1:0] t_shr;
    logic [15:0]          rnd_word;
    logic                 rnd_clip;

    logic                 s1_valid;
    logic [15:0]          s1_word;

    logic [15:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        rd_ptr;
    logic [AW-1:0]        wr_ptr;
    logic [15:0]          head;
    logic [15:0]          w_reg;

    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push;
    logic                 s1_load;
    logic                 drop;

    always_comb begin
        t_ext    = EW'(signed'(in_data)) + RND;
        t_shr    = t_ext >>> SHIFT;
        rnd_word = t_shr[15:0];
        rnd_clip = 1'b0;
        if (t_shr > MAXV) begin
            rnd_word = 16'h7fff;
            rnd_clip = 1'b1;
        end else if (t_shr < MINV) begin
            rnd_word = 16'h8000;
            rnd_clip = 1'b1;
        end
    end

    assign full  = (level == FULL);
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // The serializer takes a word when idle, or when the high byte leaves.
    assign pop  = !empty && ((state == IDLE) || ((state == HI) && out_ready));
    assign push = s1_valid && (!full || pop);

    // A blocked stage word is kept; a new result arriving behind it is lost.
    assign s1_load = !s1_valid || push;
    assign drop    = in_valid && !s1_load;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s1_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_word   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            ovf       <= 1'b0;
            sat       <= 1'b0;
            w_reg     <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            state     <= IDLE;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_word <= rnd_word;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end

            // A set event in the same cycle as a clear keeps the flag high.
            ovf <= drop | (ovf & ~clr_flags);
            sat <= (in_valid & s1_load & rnd_clip) | (sat & ~clr_flags);

            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        w_reg     <= head;
                        out_byte  <= head[7:0];
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= LO;
                    end
                end
                LO: begin
                    if (out_ready) begin
                        out_byte <= w_reg[15:8];
                        out_last <= 1'b1;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (out_ready) begin
                        if (!empty) begin
                            w_reg    <= head;
                            out_byte <= head[7:0];
                            out_last <= 1'b0;
                            state    <= LO;
                        end else begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
